uart_rx: RTL and testbench

- UART receiver: the receive end of the serial link whose transmit side drives `uart_tx`.
- Samples the asynchronous `rx` line in the system clock domain and deframes start/data/optional-parity/stop.
- Presents each received word through a single-entry valid/ready output register.
- Flags framing, parity and overrun errors as one-cycle pulses. Sits between the board `uart_rx` pin and the command/control logic.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_rx_sampler.sv | 53 +++++
 rtl/uart_rx.sv | 116 +++++++++++
 tb/tb_uart_rx.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver and the future transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

endpackage

// File: rtl/uart_rx_if.sv
// Serial input, output word slot and error pulses of the UART receiver.
interface uart_rx_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 busy;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;

  modport master (
    input  rx, rx_ready,
    output rx_data, rx_valid, busy, frame_err, parity_err, overrun
  );

  modport slave (
    output rx, rx_ready,
    input  rx_data, rx_valid, busy, frame_err, parity_err, overrun
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line front end: 2-flop synchroniser, falling-edge detect, bit timer and
// 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic timer_clr,
  output logic rx_s,
  output logic fall,
  output logic bit_val,
  output logic strobe,
  output logic wrap
);

  localparam int unsigned TW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic          samp_a;
  logic          samp_b;
  logic [TW-1:0] timer;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      prev   <= 1'b1;
      samp_a <= 1'b1;
      samp_b <= 1'b1;
      timer  <= '0;
    end else begin
      sync1 <= rx;
      sync2 <= sync1;
      prev  <= sync2;
      if (timer_clr || wrap) timer <= '0;
      else                   timer <= timer + TW'(1);
      if (timer == TW'(HALF - 1)) samp_a <= sync2;
      if (timer == TW'(HALF))     samp_b <= sync2;
    end
  end

  assign rx_s    = sync2;
  assign fall    = prev & ~sync2;
  assign strobe  = (timer == TW'(HALF + 1));
  assign wrap    = (timer == TW'(CLKS_PER_BIT - 1));
  // Third vote is the live sample, so the result is valid only while strobe is high.
  assign bit_val = (samp_a & samp_b) | (samp_a & sync2) | (samp_b & sync2);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: deframes start/data/parity/stop and presents each word
// through a single-entry valid/ready slot with one-cycle error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 144000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0
) (
  input logic     clk,
  input logic     reset,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;

  state_t               state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 par_bad;
  logic                 exp_par;
  logic                 rx_s;
  logic                 fall;
  logic                 bit_val;
  logic                 strobe;
  logic                 wrap;

  uart_rx_sampler #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_sampler (
    .clk      (clk),
    .reset    (reset),
    .rx       (bus.rx),
    .timer_clr(state == IDLE && fall),
    .rx_s     (rx_s),
    .fall     (fall),
    .bit_val  (bit_val),
    .strobe   (strobe),
    .wrap     (wrap)
  );

  always_comb begin
    exp_par = ^shreg;
    if (PARITY == PAR_ODD) exp_par = ~exp_par;
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_idx        <= '0;
      par_bad        <= 1'b0;
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.frame_err  <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.overrun    <= 1'b0;
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall && !rx_s) begin
            state   <= START;
            par_bad <= 1'b0;
          end
        end
        START: begin
          if (strobe && bit_val) begin
            state <= IDLE;
          end else if (wrap) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (strobe) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (wrap) begin
            if (bit_idx == 3'(DATA_BITS - 1))
              state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            else
              bit_idx <= bit_idx + 3'd1;
          end
        end
        uart_pkg::PARITY: begin
          if (strobe) par_bad <= (bit_val != exp_par);
          if (wrap)   state   <= STOP;
        end
        STOP: begin
          // Decide mid stop bit so a back-to-back start edge is not missed.
          if (strobe) begin
            state <= IDLE;
            if (!bit_val) begin
              bus.frame_err <= 1'b1;
            end else if (par_bad) begin
              bus.parity_err <= 1'b1;
            end else if (bus.rx_valid && !bus.rx_ready) begin
              bus.overrun <= 1'b1;
            end else begin
              bus.rx_data  <= shreg;
              bus.rx_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: 8N1 and 8E1 instances at 16 clocks per bit, checked
// against expected event lists (kind, cycle, data) built from the frame rules.
module tb_uart_rx;

  localparam int unsigned EV_VALID = 0;
  localparam int unsigned EV_FERR  = 1;
  localparam int unsigned EV_PERR  = 2;
  localparam int unsigned EV_OVR   = 3;
  // Start edge driven in cycle s is decided at s+156 and reported at s+157.
  localparam int unsigned LAT_N    = 157;
  localparam int unsigned LAT_P    = 173;

  typedef struct {
    int unsigned dut;
    int unsigned kind;
    int unsigned cyc;
    logic [7:0]  data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_valid;
    logic       exp_ferr;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  ev_t         act_q[$];
  ev_t         exp_q[$];
  logic        pv[2] = '{1'b0, 1'b0};
  logic [7:0]  pd[2] = '{8'h00, 8'h00};

  uart_rx_if #(.DATA_BITS(8)) bus ();
  uart_rx_if #(.DATA_BITS(8)) bus_p ();

  uart_rx #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(0)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  uart_rx #(.CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .PARITY(2)) dut_p (
    .clk(clk), .reset(reset), .bus(bus_p)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_act(input int unsigned d, input int unsigned k, input logic [7:0] dat);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = cyc; e.data = dat;
    act_q.push_back(e);
  endtask

  task automatic mon(input int unsigned d, input logic v, input logic [7:0] dat,
                     input logic fe, input logic pe, input logic ov);
    if (v && (!pv[d] || dat !== pd[d])) push_act(d, EV_VALID, dat);
    if (fe) push_act(d, EV_FERR, 8'h00);
    if (pe) push_act(d, EV_PERR, 8'h00);
    if (ov) push_act(d, EV_OVR, 8'h00);
    pv[d] = v;
    pd[d] = dat;
  endtask

  always @(negedge clk) begin
    mon(0, bus.rx_valid, bus.rx_data, bus.frame_err, bus.parity_err, bus.overrun);
    mon(1, bus_p.rx_valid, bus_p.rx_data, bus_p.frame_err, bus_p.parity_err, bus_p.overrun);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int unsigned d, input int unsigned k,
                           input int unsigned c, input logic [7:0] dat);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = c; e.data = dat;
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] pack_ev(input ev_t e);
    return {e.dut[0], e.kind[2:0], e.cyc[19:0], e.data};
  endfunction

  task automatic check_events(input string name);
    chk({name, " event count"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < act_q.size())
        chk($sformatf("%s event%0d", name, i), pack_ev(act_q[i]), pack_ev(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic set_rx(input int unsigned d, input logic b);
    if (d == 0) bus.rx = b;
    else        bus_p.rx = b;
  endtask

  task automatic align(output int unsigned s);
    @(posedge clk);
    #1;
    s = cyc;
  endtask

  task automatic send_bits(input int unsigned d, input logic [15:0] bits, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      set_rx(d, bits[i]);
      repeat (16) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bits(input int unsigned d, input int unsigned n);
    set_rx(d, 1'b1);
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame8(input logic [7:0] data, input logic stop);
    return {6'b0, stop, data, 1'b0};
  endfunction

  function automatic logic [15:0] frame_p(input logic [7:0] data, input logic par, input logic stop);
    return {5'b0, stop, par, data, 1'b0};
  endfunction

  task automatic drain();
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t        tbl[6];
    int unsigned s;
    int unsigned s2;
    logic [7:0]  d8;
    logic        bad;
    int unsigned gap;

    tbl[0] = '{data: 8'h00, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    tbl[1] = '{data: 8'hFF, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    tbl[2] = '{data: 8'h55, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    tbl[3] = '{data: 8'hC3, stop: 1'b0, exp_valid: 1'b0, exp_ferr: 1'b1};
    tbl[4] = '{data: 8'h80, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};
    tbl[5] = '{data: 8'h01, stop: 1'b1, exp_valid: 1'b1, exp_ferr: 1'b0};

    reset = 1'b1;
    bus.rx = 1'b1;
    bus_p.rx = 1'b1;
    bus.rx_ready = 1'b0;
    bus_p.rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("reset rx_data", 32'(bus.rx_data), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset frame_err", 32'(bus.frame_err), 32'd0);
    chk("reset parity_err", 32'(bus.parity_err), 32'd0);
    chk("reset overrun", 32'(bus.overrun), 32'd0);
    chk("reset p rx_valid", 32'(bus_p.rx_valid), 32'd0);
    chk("reset p busy", 32'(bus_p.busy), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // Table of single 8N1 frames, consumer always ready.
    bus.rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      align(s);
      send_bits(0, frame8(tbl[i].data, tbl[i].stop), 10);
      idle_bits(0, 2);
      if (tbl[i].exp_valid) expect_ev(0, EV_VALID, s + LAT_N, tbl[i].data);
      if (tbl[i].exp_ferr)  expect_ev(0, EV_FERR, s + LAT_N, 8'h00);
      check_events($sformatf("vec%0d", i));
    end

    // 0xA5 held until the consumer takes it.
    bus.rx_ready = 1'b0;
    align(s);
    send_bits(0, frame8(8'hA5, 1'b1), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_VALID, s + LAT_N, 8'hA5);
    @(negedge clk);
    chk("a5 held valid", 32'(bus.rx_valid), 32'd1);
    chk("a5 held data", 32'(bus.rx_data), 32'hA5);
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    chk("a5 valid during ready", 32'(bus.rx_valid), 32'd1);
    @(posedge clk);
    #1;
    bus.rx_ready = 1'b0;
    @(negedge clk);
    chk("a5 valid after ready", 32'(bus.rx_valid), 32'd0);
    check_events("a5");

    // 3-clock low glitch.
    align(s);
    set_rx(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    set_rx(0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("glitch busy high", 32'(bus.busy), 32'd1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("glitch busy low", 32'(bus.busy), 32'd0);
    check_events("glitch");

    // Bad stop bit, then a clean frame.
    bus.rx_ready = 1'b1;
    align(s);
    send_bits(0, frame8(8'h3C, 1'b0), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_FERR, s + LAT_N, 8'h00);
    align(s);
    send_bits(0, frame8(8'h81, 1'b1), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_VALID, s + LAT_N, 8'h81);
    check_events("frame_err");

    // Even parity: 0x07 needs parity bit 1.
    align(s);
    send_bits(1, frame_p(8'h07, 1'b0, 1'b1), 11);
    idle_bits(1, 2);
    expect_ev(1, EV_PERR, s + LAT_P, 8'h00);
    align(s);
    send_bits(1, frame_p(8'h07, 1'b1, 1'b1), 11);
    idle_bits(1, 2);
    expect_ev(1, EV_VALID, s + LAT_P, 8'h07);
    check_events("parity");

    // Back-to-back frames into a full slot.
    bus.rx_ready = 1'b0;
    align(s);
    send_bits(0, frame8(8'h11, 1'b1), 10);
    send_bits(0, frame8(8'h22, 1'b1), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_VALID, s + LAT_N, 8'h11);
    expect_ev(0, EV_OVR, s + 160 + LAT_N, 8'h00);
    chk("overrun kept data", 32'(bus.rx_data), 32'h11);
    chk("overrun kept valid", 32'(bus.rx_valid), 32'd1);
    check_events("overrun");
    drain();
    bus.rx_ready = 1'b0;

    // Same pair, consumer accepts in the load cycle of the second word.
    align(s);
    fork
      begin
        send_bits(0, frame8(8'h11, 1'b1), 10);
        send_bits(0, frame8(8'h22, 1'b1), 10);
        idle_bits(0, 2);
      end
      begin
        repeat (160 + LAT_N - 1) @(posedge clk);
        #1;
        bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_ready = 1'b0;
      end
    join
    expect_ev(0, EV_VALID, s + LAT_N, 8'h11);
    expect_ev(0, EV_VALID, s + 160 + LAT_N, 8'h22);
    chk("load-on-ready data", 32'(bus.rx_data), 32'h22);
    chk("load-on-ready valid", 32'(bus.rx_valid), 32'd1);
    check_events("load_on_ready");
    drain();
    bus.rx_ready = 1'b0;

    // Reset in the middle of data bit 4 with an old word still pending.
    align(s);
    send_bits(0, frame8(8'h33, 1'b1), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_VALID, s + LAT_N, 8'h33);
    check_events("pre_reset");
    align(s);
    d8 = 8'h5A;
    send_bits(0, frame8(d8, 1'b1), 5);
    set_rx(0, d8[4]);
    repeat (6) @(posedge clk);
    chk("mid-frame busy", 32'(bus.busy), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset rx_valid", 32'(bus.rx_valid), 32'd0);
    chk("async reset rx_data", 32'(bus.rx_data), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    set_rx(0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    idle_bits(0, 3);
    check_events("during_reset");
    bus.rx_ready = 1'b1;
    align(s);
    send_bits(0, frame8(8'h5A, 1'b1), 10);
    idle_bits(0, 2);
    expect_ev(0, EV_VALID, s + LAT_N, 8'h5A);
    check_events("post_reset");

    // Random frames and gaps; a bad stop bit is always followed by idle line.
    align(s);
    for (int i = 0; i < 16; i++) begin
      s   = cyc;
      d8  = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 4) == 0);
      gap = $urandom_range(0, 3);
      if (bad && gap == 0) gap = 1;
      send_bits(0, frame8(d8, !bad), 10);
      if (gap != 0) idle_bits(0, gap);
      if (bad) expect_ev(0, EV_FERR, s + LAT_N, 8'h00);
      else     expect_ev(0, EV_VALID, s + LAT_N, d8);
    end
    idle_bits(0, 2);
    check_events("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
